// File: rtl/fp32_operand_loader.sv
// Byte-stream loader for the FP32 multiply core: packs 8 MSB-first bytes into operands a/b,
// presents them with valid/ready, and optionally flushes subnormals to signed zero.
module fp32_operand_loader #(
    parameter bit FLUSH_SUBNORMALS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  io_in_byte,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic        io_clear,
    output logic [31:0] io_a_bits,
    output logic [31:0] io_b_bits,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [3:0]  io_count,
    output logic        io_overrun,
    output logic [1:0]  io_flushed
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(7);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   a_reg;
    logic [WORD_W-1:0]   b_reg;
    logic [CNT_W-1:0]    count;
    logic                overrun;
    logic                accept;
    logic                transfer;
    logic                a_sub;
    logic                b_sub;
    logic [4:0]          lane_lsb;

    function automatic logic is_subnormal(input logic [WORD_W-1:0] x);
        return (x[30:23] == 8'd0) && (x[22:0] != 23'd0);
    endfunction

    assign accept   = (state == COLLECT) && io_in_valid && !io_clear;
    assign transfer = (state == HOLD) && io_out_ready;
    // Byte k of a word lands at bit 31-8k, i.e. lane (3-k) counted from the LSB.
    assign lane_lsb = {~count[1:0], 3'b000};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        state_next = state;
        if (io_clear) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && (count == LAST_IDX)) state_next = HOLD;
                HOLD:    if (transfer) state_next = COLLECT;
                default: state_next = COLLECT;
            endcase
        end
    end

    // Operand assembly, byte count and sticky overrun
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (io_clear) begin
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (io_in_valid && (state == HOLD)) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                if (!count[2]) begin
                    a_reg[lane_lsb +: 8] <= io_in_byte;
                end else begin
                    b_reg[lane_lsb +: 8] <= io_in_byte;
                end
                count <= count + CNT_W'(1);
            end else if (transfer) begin
                count <= '0;
            end
        end
    end

    // Output decode and subnormal flush on the held operands
    always_comb begin
        io_in_ready  = (state == COLLECT);
        io_out_valid = (state == HOLD);
        io_count     = count;
        io_overrun   = overrun;
        a_sub        = FLUSH_SUBNORMALS && is_subnormal(a_reg);
        b_sub        = FLUSH_SUBNORMALS && is_subnormal(b_reg);
        io_a_bits    = a_sub ? {a_reg[31], 31'd0} : a_reg;
        io_b_bits    = b_sub ? {b_reg[31], 31'd0} : b_reg;
        io_flushed   = io_out_valid ? {b_sub, a_sub} : 2'b00;
    end

endmodule

// File: tb/tb_fp32_operand_loader.sv
// Self-checking bench for fp32_operand_loader: directed scenarios plus randomized operand
// streams, with one flushing and one pass-through instance sharing the same stimulus.
module tb_fp32_operand_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;

    logic        f_in_ready, f_out_valid, f_overrun;
    logic [31:0] f_a, f_b;
    logic [3:0]  f_count;
    logic [1:0]  f_flushed;
    logic        p_in_ready, p_out_valid, p_overrun;
    logic [31:0] p_a, p_b;
    logic [3:0]  p_count;
    logic [1:0]  p_flushed;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    fp32_operand_loader #(.FLUSH_SUBNORMALS(1'b1)) dut_f (
        .clock(clock), .reset(reset), .io_in_byte(in_byte), .io_in_valid(in_valid),
        .io_in_ready(f_in_ready), .io_clear(clear), .io_a_bits(f_a), .io_b_bits(f_b),
        .io_out_valid(f_out_valid), .io_out_ready(out_ready), .io_count(f_count),
        .io_overrun(f_overrun), .io_flushed(f_flushed)
    );

    fp32_operand_loader #(.FLUSH_SUBNORMALS(1'b0)) dut_p (
        .clock(clock), .reset(reset), .io_in_byte(in_byte), .io_in_valid(in_valid),
        .io_in_ready(p_in_ready), .io_clear(clear), .io_a_bits(p_a), .io_b_bits(p_b),
        .io_out_valid(p_out_valid), .io_out_ready(out_ready), .io_count(p_count),
        .io_overrun(p_overrun), .io_flushed(p_flushed)
    );

    // Reference: IEEE-754 field arithmetic on the whole word
    function automatic logic [31:0] ref_flush(input logic [31:0] x);
        int unsigned e, m;
        e = (x / 32'h0080_0000) % 256;
        m = x % 32'h0080_0000;
        if (e == 0 && m != 0) return x & 32'h8000_0000;
        return x;
    endfunction

    function automatic logic [31:0] gen_operand();
        logic [31:0] s;
        s = $urandom() & 32'h8000_0000;
        case ($urandom_range(0, 4))
            0: return s | ($urandom() % 32'h0080_0000) | 32'd1;          // subnormal
            1: return s;                                                   // zero
            2: return s | 32'h7F80_0000;                                   // inf
            3: return s | 32'h7F80_0000 | ($urandom_range(1, 32'h7F_FFFF)); // nan
            default: return s | (32'($urandom_range(1, 254)) << 23) | ($urandom() % 32'h0080_0000);
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Feeds 8 bytes with up to max_gap idle cycles between them, checking count as it goes
    task automatic load_op(input logic [31:0] a, input logic [31:0] b, input int max_gap);
        logic [63:0] word;
        int gap;
        word = {a, b};
        for (int i = 0; i < 8; i++) begin
            in_byte  = word[63-8*i -: 8];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            total_cnt++;
            if ({f_count, f_out_valid} !== {4'(i + 1), (i == 7)}) begin
                $display("FAIL load_count byte=%0d count/valid=%0d/%0b required %0d/%0b",
                         i, f_count, f_out_valid, i + 1, (i == 7));
            end else pass_cnt++;
            if (i < 7) begin
                gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) step();
                if (gap > 0) begin
                    total_cnt++;
                    if (f_count !== 4'(i + 1) || f_out_valid !== 1'b0) begin
                        $display("FAIL gap_hold byte=%0d count=%0d valid=%0b required %0d/0",
                                 i, f_count, f_out_valid, i + 1);
                    end else pass_cnt++;
                end
            end
        end
    endtask

    task automatic do_transfer();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if ({f_out_valid, f_count, f_in_ready, f_flushed} !== {1'b0, 4'd0, 1'b1, 2'b00}) begin
            $display("FAIL transfer valid=%0b count=%0d in_ready=%0b flushed=%b required 0/0/1/00",
                     f_out_valid, f_count, f_in_ready, f_flushed);
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({f_out_valid, f_count, f_a, f_b, f_overrun, f_flushed, f_in_ready} !==
            {1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b1}) begin
            $display("FAIL reset valid=%0b count=%0d a=%h b=%h ovr=%0b fl=%b rdy=%0b required zeros, rdy=1",
                     f_out_valid, f_count, f_a, f_b, f_overrun, f_flushed, f_in_ready);
        end else pass_cnt++;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        load_op(32'h4000_0000, 32'h4000_0000, 0);
        total_cnt++;
        if ({f_a, f_b, f_count, f_flushed} !== {32'h4000_0000, 32'h4000_0000, 4'd8, 2'b00}) begin
            $display("FAIL basic a=%h b=%h count=%0d fl=%b required 40000000/40000000/8/00",
                     f_a, f_b, f_count, f_flushed);
        end else pass_cnt++;
        do_transfer();
    endtask

    task automatic test_gaps();
        logic [63:0] word;
        word = 64'h4000_0000_4000_0000;
        for (int i = 0; i < 8; i++) begin
            in_byte  = word[63-8*i -: 8];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (i < 7) step();
        end
        total_cnt++;
        if ({f_out_valid, f_a, f_b, f_count} !== {1'b1, 32'h4000_0000, 32'h4000_0000, 4'd8}) begin
            $display("FAIL gaps valid=%0b a=%h b=%h count=%0d required 1/40000000/40000000/8",
                     f_out_valid, f_a, f_b, f_count);
        end else pass_cnt++;
        do_transfer();
    endtask

    task automatic test_hold_overrun();
        load_op(32'h3F80_0000, 32'hC120_0000, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_byte = 8'($urandom());
            step();
            total_cnt++;
            if ({f_out_valid, f_a, f_b, f_count, f_overrun, f_in_ready} !==
                {1'b1, 32'h3F80_0000, 32'hC120_0000, 4'd8, 1'b1, 1'b0}) begin
                $display("FAIL hold cyc=%0d valid=%0b a=%h b=%h count=%0d ovr=%0b rdy=%0b required 1/3f800000/c1200000/8/1/0",
                         i, f_out_valid, f_a, f_b, f_count, f_overrun, f_in_ready);
            end else pass_cnt++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total_cnt++;
        if ({f_out_valid, f_count, f_in_ready, f_overrun} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
            $display("FAIL post_transfer valid=%0b count=%0d rdy=%0b ovr=%0b required 0/0/1/1",
                     f_out_valid, f_count, f_in_ready, f_overrun);
        end else pass_cnt++;
    endtask

    task automatic test_clear();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_byte = 8'hA0 + 8'(i);
            step();
        end
        clear   = 1'b1;
        in_byte = 8'h55;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if ({f_count, f_overrun, f_out_valid} !== {4'd0, 1'b0, 1'b0}) begin
            $display("FAIL clear count=%0d ovr=%0b valid=%0b required 0/0/0", f_count, f_overrun, f_out_valid);
        end else pass_cnt++;
        load_op(32'h3F80_0000, 32'hC000_0000, 0);
        total_cnt++;
        if ({f_a, f_b} !== {32'h3F80_0000, 32'hC000_0000}) begin
            $display("FAIL clear_reload a=%h b=%h required 3f800000/c0000000", f_a, f_b);
        end else pass_cnt++;
        do_transfer();
    endtask

    task automatic test_flush();
        load_op(32'h8000_0001, 32'h3F80_0000, 0);
        total_cnt++;
        if ({f_a, f_b, f_flushed} !== {32'h8000_0000, 32'h3F80_0000, 2'b01}) begin
            $display("FAIL flush_on a=%h b=%h fl=%b required 80000000/3f800000/01", f_a, f_b, f_flushed);
        end else pass_cnt++;
        total_cnt++;
        if ({p_a, p_b, p_flushed} !== {32'h8000_0001, 32'h3F80_0000, 2'b00}) begin
            $display("FAIL flush_off a=%h b=%h fl=%b required 80000001/3f800000/00", p_a, p_b, p_flushed);
        end else pass_cnt++;
        do_transfer();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        int hold;
        for (int n = 0; n < 30; n++) begin
            a = gen_operand();
            b = gen_operand();
            load_op(a, b, 2);
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                total_cnt++;
                if ({f_out_valid, f_a, f_b, f_flushed} !==
                    {1'b1, ref_flush(a), ref_flush(b), (ref_flush(b) != b), (ref_flush(a) != a)}) begin
                    $display("FAIL rand_flush n=%0d a=%h b=%h fl=%b required %h/%h from %h/%h",
                             n, f_a, f_b, f_flushed, ref_flush(a), ref_flush(b), a, b);
                end else pass_cnt++;
                total_cnt++;
                if ({p_a, p_b, p_flushed, p_overrun} !== {a, b, 2'b00, 1'b0}) begin
                    $display("FAIL rand_pass n=%0d a=%h b=%h fl=%b ovr=%0b required %h/%h/00/0",
                             n, p_a, p_b, p_flushed, p_overrun, a, b);
                end else pass_cnt++;
                if (h < hold) step();
            end
            do_transfer();
        end
    endtask

    task automatic test_reset_mid_hold();
        load_op(32'h4049_0FDB, 32'h0000_0010, 0);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({f_out_valid, f_count, f_a, f_flushed} !== {1'b0, 4'd0, 32'd0, 2'b00}) begin
            $display("FAIL reset_mid_hold valid=%0b count=%0d a=%h fl=%b required 0/0/0/00",
                     f_out_valid, f_count, f_a, f_flushed);
        end else pass_cnt++;
        #1 reset = 1'b0;
        step();
        load_op(32'hBF80_0000, 32'h4080_0000, 1);
        total_cnt++;
        if ({f_a, f_b, f_overrun} !== {32'hBF80_0000, 32'h4080_0000, 1'b0}) begin
            $display("FAIL after_reset a=%h b=%h ovr=%0b required bf800000/40800000/0", f_a, f_b, f_overrun);
        end else pass_cnt++;
        do_transfer();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_hold_overrun();
        test_clear();
        test_flush();
        test_random();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
